// File: rtl/video_capture_pkg.sv
// Shared types and default constants for the video capture DMA.
package video_capture_pkg;
    typedef enum logic [2:0] {
        WAIT_FRAME_START,
        WAIT_FILL,
        ISSUE_ADDR,
        BURST_ACTIVE,
        WAIT_RESP
    } capture_state_t;

    localparam int          DFLT_FRAME_PIXELS = 307200;
    localparam int          DFLT_BURST_LENGTH = 64;
    localparam int          DFLT_FIFO_LENGTH  = 128;
    localparam logic [31:0] DFLT_FB_ADDR      = 32'h1000_0000;
endpackage

// File: rtl/video_capture_dma_if.sv
// AXI write-channel subset used by the capture DMA (AW, W and B only).
interface axi_interface;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    modport master (
        output awaddr, awlen, awvalid, wdata, wlast, wvalid, bready,
        input  awready, wready, bvalid
    );
    modport slave (
        input  awaddr, awlen, awvalid, wdata, wlast, wvalid, bready,
        output awready, wready, bvalid
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; a push coincident with flush lands in the emptied FIFO.
module sync_fifo #(
    parameter int DATA_WIDTH             = 32,
    parameter int NUM_ENTRIES            = 16,
    parameter int ALMOST_EMPTY_THRESHOLD = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_empty_o
);
    localparam int PTR_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam int CNT_W = $clog2(NUM_ENTRIES + 1);

    logic [DATA_WIDTH-1:0] mem [NUM_ENTRIES];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr, wr_idx;
    logic [CNT_W-1:0]      count;
    logic                  do_push, do_pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_ENTRIES - 1)) ? '0 : p + 1'b1;
    endfunction

    // Push into a full FIFO is dropped unless a flush frees it in the same cycle.
    assign do_push        = push_i && (flush_i || !full_o);
    assign do_pop         = pop_i && !empty_o && !flush_i;
    assign wr_idx         = flush_i ? '0 : wr_ptr;
    assign data_o         = mem[rd_ptr];
    assign full_o         = (count == CNT_W'(NUM_ENTRIES));
    assign empty_o        = (count == '0);
    assign almost_empty_o = (count <= CNT_W'(ALMOST_EMPTY_THRESHOLD));

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_idx] <= data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= do_push ? PTR_W'(1) : '0;
            count  <= CNT_W'(do_push);
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end
endmodule

// File: rtl/video_capture_dma.sv
// Captures one pixel frame into a FIFO and writes it to memory as fixed-length AXI bursts,
// padding with zero beats once the input is finished so every frame is FRAME_PIXELS beats.
module video_capture_dma
    import video_capture_pkg::*;
#(
    parameter int          FRAME_PIXELS    = DFLT_FRAME_PIXELS,
    parameter int          BURST_LENGTH    = DFLT_BURST_LENGTH,
    parameter int          FIFO_LENGTH     = DFLT_FIFO_LENGTH,
    parameter logic [31:0] DEFAULT_FB_ADDR = DFLT_FB_ADDR
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         frame_start,
    input  logic         pixel_valid,
    input  logic [31:0]  pixel_data,
    input  logic [31:0]  fb_base_address,
    output logic         frame_done,
    output logic         overflow,
    output logic         frame_error,
    axi_interface.master axi_bus
);
    localparam int NUM_BURSTS = FRAME_PIXELS / BURST_LENGTH;
    localparam int IN_W       = $clog2(FRAME_PIXELS + 1);
    localparam int BI_W       = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam int BC_W       = $clog2(BURST_LENGTH);
    localparam logic [IN_W-1:0] LAST_PIXEL   = IN_W'(FRAME_PIXELS - 1);
    localparam logic [BI_W-1:0] LAST_BURST   = BI_W'(NUM_BURSTS - 1);
    localparam logic [BC_W-1:0] PENULT_BEAT  = BC_W'(BURST_LENGTH - 2);
    localparam logic [31:0]     BURST_BYTES  = 32'(BURST_LENGTH * 4);

    capture_state_t  state;
    logic            capturing;
    logic [IN_W-1:0] in_count;
    logic [BI_W-1:0] burst_index;
    logic [BC_W-1:0] beat_count;
    logic [31:0]     addr;
    logic            awvalid_q, wlast_q;
    logic            accept, take, w_fire, pop;
    logic            fifo_full, fifo_empty, fifo_almost_empty;
    logic [31:0]     fifo_head;

    // frame_done marks the cycle the FSM leaves WAIT_RESP, so a start then is still rejected.
    assign accept = frame_start && !capturing && (state == WAIT_FRAME_START) && !frame_done;
    assign take   = pixel_valid && (capturing || accept);
    assign w_fire = axi_bus.wvalid && axi_bus.wready;
    assign pop    = w_fire && !fifo_empty;

    sync_fifo #(
        .DATA_WIDTH             (32),
        .NUM_ENTRIES            (FIFO_LENGTH),
        .ALMOST_EMPTY_THRESHOLD (BURST_LENGTH - 1)
    ) u_fifo (
        .clk            (clk),
        .rst_n          (reset_n),
        .flush_i        (accept),
        .push_i         (take),
        .data_i         (pixel_data),
        .pop_i          (pop),
        .data_o         (fifo_head),
        .full_o         (fifo_full),
        .empty_o        (fifo_empty),
        .almost_empty_o (fifo_almost_empty)
    );

    assign axi_bus.awaddr  = addr;
    assign axi_bus.awlen   = 8'(BURST_LENGTH - 1);
    assign axi_bus.awvalid = awvalid_q;
    assign axi_bus.wvalid  = (state == BURST_ACTIVE) && (!fifo_empty || !capturing);
    assign axi_bus.wdata   = fifo_empty ? 32'h0 : fifo_head;
    assign axi_bus.wlast   = wlast_q;
    assign axi_bus.bready  = 1'b1;

    // Dropped pixels still count toward the frame so capture always terminates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            capturing   <= 1'b0;
            in_count    <= '0;
            overflow    <= 1'b0;
            frame_error <= 1'b0;
        end else if (accept) begin
            capturing   <= 1'b1;
            in_count    <= IN_W'(take);
            overflow    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            if (frame_start) frame_error <= 1'b1;
            if (take) begin
                in_count <= in_count + 1'b1;
                if (fifo_full) overflow <= 1'b1;
                if (in_count == LAST_PIXEL) capturing <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= WAIT_FRAME_START;
            addr        <= DEFAULT_FB_ADDR;
            burst_index <= '0;
            beat_count  <= '0;
            awvalid_q   <= 1'b0;
            wlast_q     <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                WAIT_FRAME_START: if (accept) begin
                    addr        <= fb_base_address;
                    burst_index <= '0;
                    state       <= WAIT_FILL;
                end
                WAIT_FILL: if (!fifo_almost_empty || !capturing) begin
                    awvalid_q <= 1'b1;
                    state     <= ISSUE_ADDR;
                end
                ISSUE_ADDR: if (axi_bus.awready) begin
                    awvalid_q  <= 1'b0;
                    beat_count <= '0;
                    wlast_q    <= (BURST_LENGTH == 1);
                    state      <= BURST_ACTIVE;
                end
                BURST_ACTIVE: if (w_fire) begin
                    beat_count <= beat_count + 1'b1;
                    wlast_q    <= (beat_count == PENULT_BEAT);
                    if (wlast_q) begin
                        wlast_q <= 1'b0;
                        state   <= WAIT_RESP;
                    end
                end
                WAIT_RESP: if (axi_bus.bvalid) begin
                    if (burst_index == LAST_BURST) begin
                        frame_done <= 1'b1;
                        state      <= WAIT_FRAME_START;
                    end else begin
                        addr        <= addr + BURST_BYTES;
                        burst_index <= burst_index + 1'b1;
                        state       <= WAIT_FILL;
                    end
                end
                default: state <= WAIT_FRAME_START;
            endcase
        end
    end
endmodule
